tcon_dither: RTL and testbench
==============================

TCON_DITHER -- requirements
Module: tcon_dither

Interface
REQ-001 SHALL have parameter IN_DW, default 12, input component width (degamma output width).
REQ-002 SHALL have parameter OUT_DW, default 8, output component width; D = IN_DW-OUT_DW, D=4 by default.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port vsync_in  input  1  frame sync from upstream degamma stage.
REQ-006 SHALL have port de_in  input  1  data enable; high for active pixels.
REQ-007 SHALL have ports r_in/g_in/b_in  input  IN_DW each  linear pixel components.
REQ-008 SHALL have port reg_dither_en  input  1  dither enable, 0 = plain truncation.
REQ-009 SHALL have port vsync_out  output  1  vsync_in delayed by pipeline latency.
REQ-010 SHALL have port de_out  output  1  de_in delayed by pipeline latency.
REQ-011 SHALL have ports r_out/g_out/b_out  output  OUT_DW each  dithered components.

Function
REQ-012 Pixel counter x: +1 per cycle with de_in=1; cleared on de_in falling edge; 12 bits, wraps silently; only x[1:0] used.
REQ-013 Line counter y: +1 on de_in falling edge; cleared on vsync_in rising edge; 12 bits, wraps; only y[1:0] used.
REQ-014 Threshold T = Bayer4x4[yi][xi], rows: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5; xi=x[1:0], yi=y[1:0] (temporal offset per REQ-024).
REQ-015 T SHALL be scaled to D bits: T >> (4-D) when D<4, T << (D-4) when D>4.
REQ-016 Stage 1: sum = in + T, IN_DW+1 bits, per component, same T for R/G/B.
REQ-017 Stage 2: out = sum >> D, saturated to 2^OUT_DW-1 (4095+15 -> 255, never wraps to 0).
REQ-018 Dither disabled (shadow en=0): out = in >> D, same latency as enabled.
REQ-019 Latency SHALL be exactly 2 cycles for data, de_out and vsync_out, all aligned.
REQ-020 r/g/b_out SHALL be 0 in any cycle where de_out=0.
REQ-021 reg_dither_en sampled into shadow register only on vsync_in rising edge; mid-frame changes take effect next frame.
REQ-022 vsync_in rising mid-line: y cleared, x continues until de_in falls; no error state.

Reset
REQ-023 rstn=0 SHALL asynchronously clear counters, pipeline, shadow enable, frame counter and all outputs to 0; first frame after reset processed with shadow en=0 until first vsync_in rising edge.

Configuration
REQ-024 Macro DITHER_TEMPORAL_EN defined: 2-bit frame counter, +1 on each vsync_in rising edge (wraps 3->0); xi=(x+2*f[0])[1:0], yi=(y+2*f[1])[1:0].
REQ-025 Macro DITHER_TEMPORAL_EN undefined: no frame counter; xi=x[1:0], yi=y[1:0]; pattern identical every frame.

Verification
REQ-026 Reset: rstn=0 mid-frame -> all outputs 0 same cycle; after release, outputs track input with 2-cycle latency.
REQ-027 en=0, flat input 2040 (0x7F8) -> all outputs 127, de_out/vsync_out exactly 2 cycles after inputs.
REQ-028 en=1 (set before vsync), flat 2056 -> row0 128 129 128 129, row1 129 128 129 128, row2 128 129 128 129, row3 129 128 129 128, repeating.
REQ-029 en=1, flat 4095 -> every output 255 (saturation, no wrap); flat 0 -> every output 0.
REQ-030 With DITHER_TEMPORAL_EN, flat 2056, frame 1 row0 -> 128 129 128 129 shifted two columns, frame 2 pattern shifted two rows; without macro all frames equal frame 0.
REQ-031 Toggle reg_dither_en 0->1 at mid-frame -> current frame stays truncated (127 for 2040 case), dither starts at next vsync_in rising edge.

Source files
------------

// File: rtl/tcon_dither_if.sv
// Pixel bus into and out of the TCON dither stage (sync, enable and RGB components).
// The master drives the *_in side; the slave (the dither block) drives the *_out side.
interface tcon_dither_if #(
  parameter int IN_DW  = 12,
  parameter int OUT_DW = 8
);
  logic              vsync_in;
  logic              de_in;
  logic [IN_DW-1:0]  r_in;
  logic [IN_DW-1:0]  g_in;
  logic [IN_DW-1:0]  b_in;
  logic              vsync_out;
  logic              de_out;
  logic [OUT_DW-1:0] r_out;
  logic [OUT_DW-1:0] g_out;
  logic [OUT_DW-1:0] b_out;

  modport master (
    output vsync_in, de_in, r_in, g_in, b_in,
    input  vsync_out, de_out, r_out, g_out, b_out
  );

  modport slave (
    input  vsync_in, de_in, r_in, g_in, b_in,
    output vsync_out, de_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/tcon_dither.sv
// Ordered 4x4 Bayer dither IN_DW->OUT_DW with saturation; DITHER_TEMPORAL_EN adds a per-frame offset.
// Latency 2 cycles for data/de/vsync; no backpressure (free-running video timing).
module tcon_dither #(
  parameter int IN_DW  = 12,
  parameter int OUT_DW = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         reg_dither_en,
  tcon_dither_if.slave pix
);
  localparam int D    = IN_DW - OUT_DW;
  localparam int SH_L = (D > 4) ? D - 4 : 0;
  localparam int SH_R = (D < 4) ? 4 - D : 0;

  logic [11:0]    x_cnt;
  logic [11:0]    y_cnt;
  logic           de_d;
  logic           vs_d;
  logic           en_shadow;
  logic           de_fall;
  logic           vs_rise;
  logic [1:0]     xi;
  logic [1:0]     yi;
  logic [3:0]     t_raw;
  logic [IN_DW:0] t_sc;
  logic [IN_DW:0] t_add;
  logic           s1_de;
  logic           s1_vs;
  logic [IN_DW:0] s1_r;
  logic [IN_DW:0] s1_g;
  logic [IN_DW:0] s1_b;

  assign de_fall = de_d & ~pix.de_in;
  assign vs_rise = ~vs_d & pix.vsync_in;

`ifdef DITHER_TEMPORAL_EN
  logic [1:0] frame_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
    end else if (vs_rise) begin
      frame_cnt <= frame_cnt + 2'd1;
    end
  end

  // Two-step shifts of the matrix each frame spread the residual pattern over time.
  assign xi = x_cnt[1:0] + {frame_cnt[0], 1'b0};
  assign yi = y_cnt[1:0] + {frame_cnt[1], 1'b0};
`else
  assign xi = x_cnt[1:0];
  assign yi = y_cnt[1:0];
`endif

  always_comb begin
    t_raw = 4'd0;
    case ({yi, xi})
      4'h0: t_raw = 4'd0;
      4'h1: t_raw = 4'd8;
      4'h2: t_raw = 4'd2;
      4'h3: t_raw = 4'd10;
      4'h4: t_raw = 4'd12;
      4'h5: t_raw = 4'd4;
      4'h6: t_raw = 4'd14;
      4'h7: t_raw = 4'd6;
      4'h8: t_raw = 4'd3;
      4'h9: t_raw = 4'd11;
      4'hA: t_raw = 4'd1;
      4'hB: t_raw = 4'd9;
      4'hC: t_raw = 4'd15;
      4'hD: t_raw = 4'd7;
      4'hE: t_raw = 4'd13;
      4'hF: t_raw = 4'd5;
      default: t_raw = 4'd0;
    endcase
  end

  assign t_sc  = ((IN_DW+1)'(t_raw) << SH_L) >> SH_R;
  assign t_add = en_shadow ? t_sc : '0;

  function automatic logic [OUT_DW-1:0] sat(input logic [IN_DW:0] s);
    logic [OUT_DW:0] q;
    q = s[IN_DW:D];
    return q[OUT_DW] ? {OUT_DW{1'b1}} : q[OUT_DW-1:0];
  endfunction

  // Position counters and the frame-synchronous copy of the enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      de_d      <= 1'b0;
      vs_d      <= 1'b0;
      en_shadow <= 1'b0;
    end else begin
      de_d <= pix.de_in;
      vs_d <= pix.vsync_in;
      if (pix.de_in) begin
        x_cnt <= x_cnt + 12'd1;
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (vs_rise) begin
        y_cnt     <= '0;
        en_shadow <= reg_dither_en;
      end else if (de_fall) begin
        y_cnt <= y_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_de         <= 1'b0;
      s1_vs         <= 1'b0;
      s1_r          <= '0;
      s1_g          <= '0;
      s1_b          <= '0;
      pix.de_out    <= 1'b0;
      pix.vsync_out <= 1'b0;
      pix.r_out     <= '0;
      pix.g_out     <= '0;
      pix.b_out     <= '0;
    end else begin
      s1_de         <= pix.de_in;
      s1_vs         <= pix.vsync_in;
      s1_r          <= {1'b0, pix.r_in} + t_add;
      s1_g          <= {1'b0, pix.g_in} + t_add;
      s1_b          <= {1'b0, pix.b_in} + t_add;
      pix.de_out    <= s1_de;
      pix.vsync_out <= s1_vs;
      pix.r_out     <= s1_de ? sat(s1_r) : '0;
      pix.g_out     <= s1_de ? sat(s1_g) : '0;
      pix.b_out     <= s1_de ? sat(s1_b) : '0;
    end
  end
endmodule

// File: tb/tb_tcon_dither.sv
// Scoreboard bench for tcon_dither: a spec-level model predicts each pixel, compared two cycles later.
module tb_tcon_dither;
  localparam int IN_DW  = 12;
  localparam int OUT_DW = 8;
  localparam int D      = IN_DW - OUT_DW;

  typedef struct packed {
    logic       de;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic reg_dither_en;

  tcon_dither_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) dif ();

  tcon_dither #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .reg_dither_en (reg_dither_en),
    .pix           (dif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sbq[$];

  int bayer[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // Reference state tracked from the input stream.
  int mx, my, mf;
  bit mde, mvs, men;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  function automatic int exp_comp(input int v, input int t, input bit en);
    int s;
    s = (v + (en ? t : 0)) >> D;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mf = 0; mde = 0; mvs = 0; men = 0;
    sbq.delete();
    sbq.push_back('0);
  endtask

  task automatic pix(input bit de, input bit vs, input int r, input int g, input int b);
    exp_t e;
    exp_t o;
    int xi, yi, t;
    bit fall, rise;
    dif.de_in    = de;
    dif.vsync_in = vs;
    dif.r_in     = 12'(r);
    dif.g_in     = 12'(g);
    dif.b_in     = 12'(b);
`ifdef DITHER_TEMPORAL_EN
    xi = (mx + 2 * (mf % 2)) % 4;
    yi = (my + 2 * (mf / 2)) % 4;
`else
    xi = mx % 4;
    yi = my % 4;
`endif
    t    = bayer[yi][xi];
    e.de = de;
    e.vs = vs;
    e.r  = de ? 8'(exp_comp(r, t, men)) : 8'd0;
    e.g  = de ? 8'(exp_comp(g, t, men)) : 8'd0;
    e.b  = de ? 8'(exp_comp(b, t, men)) : 8'd0;
    sbq.push_back(e);
    fall = mde & ~de;
    rise = ~mvs & vs;
    if (de) mx = (mx + 1) % 4096;
    else if (fall) mx = 0;
    if (rise) begin
      my  = 0;
      men = reg_dither_en;
      mf  = (mf + 1) % 4;
    end else if (fall) begin
      my = (my + 1) % 4096;
    end
    mde = de;
    mvs = vs;
    @(posedge clk);
    #1;
    if (sbq.size() >= 2) begin
      o = sbq.pop_front();
      chk("de_out", int'(dif.de_out), int'(o.de));
      chk("vsync_out", int'(dif.vsync_out), int'(o.vs));
      chk("r_out", int'(dif.r_out), int'(o.r));
      chk("g_out", int'(dif.g_out), int'(o.g));
      chk("b_out", int'(dif.b_out), int'(o.b));
    end
  endtask

  task automatic line(input int v, input bit rnd);
    int r, g, b;
    for (int i = 0; i < 8; i++) begin
      r = rnd ? int'($urandom_range(0, 4095)) : v;
      g = rnd ? int'($urandom_range(0, 4095)) : v;
      b = rnd ? int'($urandom_range(0, 4095)) : v;
      pix(1'b1, 1'b0, r, g, b);
    end
    pix(1'b0, 1'b0, v, v, v);
    pix(1'b0, 1'b0, v, v, v);
  endtask

  task automatic frame(input int v, input bit rnd);
    pix(1'b0, 1'b1, v, v, v);
    pix(1'b0, 1'b0, v, v, v);
    for (int l = 0; l < 4; l++) line(v, rnd);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_de"}, int'(dif.de_out), 0);
    chk({tag, "_vs"}, int'(dif.vsync_out), 0);
    chk({tag, "_r"}, int'(dif.r_out), 0);
    chk({tag, "_g"}, int'(dif.g_out), 0);
    chk({tag, "_b"}, int'(dif.b_out), 0);
  endtask

  initial begin
    rstn          = 1'b0;
    reg_dither_en = 1'b0;
    dif.de_in     = 1'b0;
    dif.vsync_in  = 1'b0;
    dif.r_in      = '0;
    dif.g_in      = '0;
    dif.b_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    #6 rstn = 1'b1;
    model_reset();

    // Shadow enable stays 0 until the first vsync even with the register set.
    reg_dither_en = 1'b1;
    line(2056, 1'b0);

    reg_dither_en = 1'b0;
    frame(2040, 1'b0);

    reg_dither_en = 1'b1;
    frame(2056, 1'b0);
    frame(2056, 1'b0);
    frame(4095, 1'b0);
    frame(0, 1'b0);

    // Enable raised mid-frame only applies from the next vsync.
    reg_dither_en = 1'b0;
    pix(1'b0, 1'b1, 2040, 2040, 2040);
    pix(1'b0, 1'b0, 2040, 2040, 2040);
    line(2040, 1'b0);
    reg_dither_en = 1'b1;
    line(2040, 1'b0);
    line(2040, 1'b0);
    frame(2040, 1'b0);

    // Random content, then a vsync arriving in the middle of an active line.
    frame(0, 1'b1);
    line(0, 1'b1);
    for (int i = 0; i < 8; i++)
      pix(1'b1, i == 3, int'($urandom_range(0, 4095)), 2056, int'($urandom_range(0, 4095)));
    pix(1'b0, 1'b0, 0, 0, 0);
    line(2056, 1'b0);
    line(0, 1'b1);

    // Asynchronous reset in the middle of an active line.
    pix(1'b1, 1'b0, 2056, 2056, 2056);
    pix(1'b1, 1'b0, 2056, 2056, 2056);
    #3 rstn = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    model_reset();
    #2 rstn = 1'b1;
    frame(2056, 1'b0);
    frame(4095, 1'b1);
    pix(1'b0, 1'b0, 0, 0, 0);
    pix(1'b0, 1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
